// File: rtl/sram_pkg.sv
// Shared types and helpers for the lane-masked 1RW SRAM model.
// Covers the init-sweep state encoding and lane bit-slice arithmetic.
package sram_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } sweep_state_e;

   // Lowest bit index of a lane inside a packed word.
   function automatic int lane_lo(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/sram_init_sweeper.sv
// Post-reset clear sequencer: walks every word once, then declares the array ready.
// Owns the sweep counter, the INIT/READY state and the ready flag.
module sram_init_sweeper
   import sram_pkg::*;
#(
   parameter int ADDR_WIDTH    = 4,
   parameter int RAM_DEPTH     = 1 << ADDR_WIDTH,
   parameter bit INIT_ON_RESET = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   output logic                  ready_o,
   output logic                  sweep_we_o,
   output logic [ADDR_WIDTH-1:0] sweep_addr_o
);

   // One extra counter bit keeps the terminal compare unambiguous for any depth.
   localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(RAM_DEPTH - 1);

   sweep_state_e          state_q, state_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= INIT_ON_RESET ? ST_INIT : ST_READY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            state_d = ST_READY;
         end
      end
   end

   always_comb begin
      ready_o      = (state_q == ST_READY);
      sweep_we_o   = (state_q == ST_INIT) && !rst_i;
      sweep_addr_o = cnt_q[ADDR_WIDTH-1:0];
   end

endmodule

// File: rtl/sram_1rw_lanemask.sv
// Single-port SRAM behavioural model with per-lane write mask and post-reset clear.
// Registered inputs, write commits one edge after capture, read is combinational from the registered address.
module sram_1rw_lanemask
   import sram_pkg::*;
#(
   parameter int                    DATA_WIDTH    = 8,
   parameter int                    LANES         = 4,
   parameter int                    ADDR_WIDTH    = 4,
   parameter int                    RAM_DEPTH     = 1 << ADDR_WIDTH,
   parameter bit                    INIT_ON_RESET = 1'b1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
   input  logic                        clk0,
   input  logic                        rst0,
   input  logic                        csb0,
   input  logic                        web0,
   input  logic [LANES-1:0]            wmask0,
   input  logic [ADDR_WIDTH-1:0]       addr0,
   input  logic [LANES*DATA_WIDTH-1:0] din0,
   output logic [LANES*DATA_WIDTH-1:0] dout0,
   output logic                        ready0
);

   localparam int WORD_W = LANES * DATA_WIDTH;
   localparam logic [WORD_W-1:0] SWEEP_WORD = {LANES{INIT_VALUE}};

   logic [WORD_W-1:0]     mem [RAM_DEPTH];

   logic                  sweep_we;
   logic [ADDR_WIDTH-1:0] sweep_addr;

   logic                  pend_q, pend_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LANES-1:0]      wmask_q, wmask_d;
   logic [WORD_W-1:0]     din_q, din_d;

   sram_init_sweeper #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .RAM_DEPTH    (RAM_DEPTH),
      .INIT_ON_RESET(INIT_ON_RESET)
   ) u_sweeper (
      .clk_i       (clk0),
      .rst_i       (rst0),
      .ready_o     (ready0),
      .sweep_we_o  (sweep_we),
      .sweep_addr_o(sweep_addr)
   );

   // A deselected cycle drops the pending write but keeps the address, so dout0 keeps reading the same word.
   always_comb begin
      pend_d  = 1'b0;
      addr_d  = addr_q;
      wmask_d = wmask_q;
      din_d   = din_q;
      if (ready0 && !csb0) begin
         pend_d  = !web0;
         addr_d  = addr0;
         wmask_d = wmask0;
         din_d   = din0;
      end
   end

   always_ff @(posedge clk0) begin
      if (rst0) begin
         pend_q <= 1'b0;
         addr_q <= '0;
      end else begin
         pend_q <= pend_d;
         addr_q <= addr_d;
      end
   end

   always_ff @(posedge clk0) begin
      if (!rst0) begin
         wmask_q <= wmask_d;
         din_q   <= din_d;
      end
   end

   // Sweep and user writes never overlap: a write can only be pending once the sweep is done.
   always_ff @(posedge clk0) begin
      if (sweep_we) begin
         mem[sweep_addr] <= SWEEP_WORD;
      end else if (pend_q && !rst0) begin
         for (int i = 0; i < LANES; i++) begin
            if (wmask_q[i]) begin
               mem[addr_q][lane_lo(i, DATA_WIDTH) +: DATA_WIDTH] <=
                  din_q[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH];
            end
         end
      end
   end

   assign dout0 = ready0 ? mem[addr_q] : '0;

endmodule
